// File: rtl/seletor_menor_custo.sv
// seletor_menor_custo
//   Scans the active-node slots one per cycle and returns the index and cost
//   of the enabled slot with the lowest cost (the next node to expand).
//   Ties resolve to the lowest index. "Empty" is reported when no slot is
//   enabled.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   ST_IDLE     | waiting for iniciar_in; last result held on the outputs
//   ST_VARRENDO | examining snapshot slot [idx], one slot per cycle
//   ST_PRONTO   | one-cycle result strobe; may restart on iniciar_in
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   iniciar_in            start-search pulse
//   habilitar_in          per-slot enable, bit i = slot i active
//   custo_in              slot i cost at [i*CUSTO_WIDTH +: CUSTO_WIDTH]
//   ocupado_out           high while a scan is in progress
//   pronto_out            one-cycle pulse, result valid
//   vazio_out             with pronto_out: no slot was enabled
//   menor_endereco_out    index of the minimum-cost enabled slot
//   menor_custo_out       cost of that slot
module seletor_menor_custo #(
    parameter int NUM_NA      = 8,
    parameter int CUSTO_WIDTH = 8,
    parameter int IDX_WIDTH   = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          iniciar_in,
    input  logic [NUM_NA-1:0]             habilitar_in,
    input  logic [NUM_NA*CUSTO_WIDTH-1:0] custo_in,
    output logic                          ocupado_out,
    output logic                          pronto_out,
    output logic                          vazio_out,
    output logic [IDX_WIDTH-1:0]          menor_endereco_out,
    output logic [CUSTO_WIDTH-1:0]        menor_custo_out
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_VARRENDO = 2'd1,
        ST_PRONTO   = 2'd2
    } estado_t;

    estado_t estado, prox_estado;

    logic [NUM_NA-1:0]             hab_snap;
    logic [NUM_NA*CUSTO_WIDTH-1:0] custo_snap;
    logic [IDX_WIDTH-1:0]          idx;
    logic                          achou;
    logic [IDX_WIDTH-1:0]          melhor_idx;
    logic [CUSTO_WIDTH-1:0]        melhor_custo;

    logic                          carregar;
    logic                          ultimo;
    logic                          melhora;
    logic [CUSTO_WIDTH-1:0]        custo_atual;
    logic                          prox_achou;
    logic [IDX_WIDTH-1:0]          prox_melhor_idx;
    logic [CUSTO_WIDTH-1:0]        prox_melhor_custo;

    // Evaluation of the current slot. Strict '<' keeps the earlier (lower)
    // index on ties; the first enabled slot always wins regardless of cost,
    // so an all-ones cost is still selectable.
    always_comb begin
        custo_atual       = custo_snap[idx*CUSTO_WIDTH +: CUSTO_WIDTH];
        ultimo            = (idx == IDX_WIDTH'(NUM_NA-1));
        melhora           = hab_snap[idx] && (!achou || (custo_atual < melhor_custo));
        prox_achou        = achou | melhora;
        prox_melhor_idx   = melhora ? idx : melhor_idx;
        prox_melhor_custo = melhora ? custo_atual : melhor_custo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= ST_IDLE;
        end else begin
            estado <= prox_estado;
        end
    end

    always_comb begin
        prox_estado = estado;
        carregar    = 1'b0;
        ocupado_out = 1'b0;
        pronto_out  = 1'b0;
        case (estado)
            ST_IDLE: begin
                if (iniciar_in) begin
                    carregar    = 1'b1;
                    prox_estado = ST_VARRENDO;
                end
            end
            ST_VARRENDO: begin
                // iniciar_in is deliberately ignored here, not queued
                ocupado_out = 1'b1;
                if (ultimo) begin
                    prox_estado = ST_PRONTO;
                end
            end
            ST_PRONTO: begin
                pronto_out = 1'b1;
                if (iniciar_in) begin
                    carregar    = 1'b1;
                    prox_estado = ST_VARRENDO;
                end else begin
                    prox_estado = ST_IDLE;
                end
            end
            default: prox_estado = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hab_snap           <= '0;
            custo_snap         <= '0;
            idx                <= '0;
            achou              <= 1'b0;
            melhor_idx         <= '0;
            melhor_custo       <= '0;
            vazio_out          <= 1'b0;
            menor_endereco_out <= '0;
            menor_custo_out    <= '0;
        end else if (carregar) begin
            hab_snap     <= habilitar_in;
            custo_snap   <= custo_in;
            idx          <= '0;
            achou        <= 1'b0;
            melhor_idx   <= '0;
            melhor_custo <= '0;
        end else if (estado == ST_VARRENDO) begin
            achou        <= prox_achou;
            melhor_idx   <= prox_melhor_idx;
            melhor_custo <= prox_melhor_custo;
            if (ultimo) begin
                // Result registers are loaded on the way into ST_PRONTO so they
                // are valid during the strobe and held until the next one.
                vazio_out          <= ~prox_achou;
                menor_endereco_out <= prox_achou ? prox_melhor_idx : '0;
                menor_custo_out    <= prox_achou ? prox_melhor_custo : '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: doc/seletor_menor_custo.md
Name: seletor_menor_custo

Overview:
- Sits directly downstream of the active-node manager in the path-search datapath.
- Consumes the manager's per-slot enable vector plus a flattened cost vector for the NUM_NA active-node slots.
- Sequentially scans the slots, one per cycle, and returns the index and cost of the enabled slot with the lowest cost. This is the next node to expand.
- Reports "empty" when no slot is enabled.

Parameters:
- NUM_NA, 8, number of active-node slots (≥2).
- CUSTO_WIDTH, 8, width of one slot's cost, unsigned.
- IDX_WIDTH, 3, slot index width; must satisfy 2**IDX_WIDTH ≥ NUM_NA.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- iniciar_in  input  1  start-search pulse.
- habilitar_in  input  NUM_NA  per-slot enable from the active-node manager; bit i=1 means slot i is active.
- custo_in  input  NUM_NA*CUSTO_WIDTH  slot i cost at bits [i*CUSTO_WIDTH +: CUSTO_WIDTH].
- ocupado_out  output  1  high while a scan is in progress.
- pronto_out  output  1  one-cycle pulse: result valid.
- vazio_out  output  1  valid with pronto_out; 1 = no slot was enabled.
- menor_endereco_out  output  IDX_WIDTH  index of the minimum-cost enabled slot.
- menor_custo_out  output  CUSTO_WIDTH  cost of that slot.

Behaviour:
- Reset (async, any state): state=ST_IDLE; all outputs 0; internal snapshot, index counter and best-so-far registers cleared.
- FSM states: ST_IDLE, ST_VARRENDO, ST_PRONTO.
  - ST_IDLE: when iniciar_in=1, capture habilitar_in and custo_in into snapshot registers, clear index to 0, clear found-flag, then go to ST_VARRENDO.
  - ST_VARRENDO: ocupado_out=1. Each cycle examine snapshot slot [index]. If it is enabled and either found-flag=0 or its cost < best cost (strictly less), load best index/cost and set found-flag. When index==NUM_NA-1, go to ST_PRONTO; otherwise increment index.
  - ST_PRONTO: pronto_out=1 for exactly this cycle; vazio_out = ~found-flag. Return to ST_IDLE, or restart (snapshot + ST_VARRENDO) if iniciar_in=1 in this cycle.
- Latency: iniciar_in sampled at edge N gives pronto_out high during cycle N+NUM_NA+1. Throughput is one search per NUM_NA+1 cycles when back-to-back.
- Result hold:
  - menor_endereco_out, menor_custo_out and vazio_out are registered and hold their last result until the next ST_PRONTO.
  - When vazio_out=1, menor_endereco_out=0 and menor_custo_out=0.
- Tie rule: equal minimum costs resolve to the lowest index.
- Snapshot rule: changes on habilitar_in/custo_in after the start cycle do not affect the current search.
- iniciar_in in ST_VARRENDO is ignored (not queued).
- Costs are unsigned. All-ones is a legal cost, not a sentinel.
- Reset mid-scan aborts the search with no pronto_out; the next start behaves as after power-up.

Test Plan:
- NUM_NA=8, habilitar=8'b0001_0000, cost[4]=37 → pronto 9 cycles after start; endereco=4, custo=37, vazio=0.
- All enabled, costs {9,3,7,3,5,8,6,4} for slots 0..7 → endereco=1, custo=3 (tie with slot 3 resolved to lower index).
- habilitar=0 → pronto after 9 cycles with vazio=1, endereco=0, custo=0.
- Only slot 7 enabled, cost 8'hFF, others enabled=0 with cost 0 → endereco=7, custo=255.
- Start, then change habilitar/custo and pulse iniciar_in mid-scan → result reflects the original snapshot; exactly one pronto pulse. iniciar_in held high during ST_PRONTO → second search starts; second pronto arrives 9 cycles after the first.
- Assert rst_n low at cycle 4 of a scan → all outputs 0 immediately, no pronto. New start after release gives the correct result with normal latency.
